// File: rtl/g_reg_scoreboard.sv
// General-register file with a per-register pending-write scoreboard.
// Decode reads operands and reserves destinations. Execute writes results back.
// Each register keeps a small counter of outstanding writes, so back-to-back
// writers to one destination can be in flight at the same time.
// Optional build macro: VENUS_REG_BYPASS_EN adds same-cycle write-back
// forwarding onto the read ports.
module g_reg_scoreboard #(
    parameter int W_OPR   = 32,
    parameter int N_REG   = 16,
    parameter int W_RD    = 4,
    parameter int W_CNT   = 2,
    parameter int ZERO_R0 = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W_RD-1:0]  r0_i,
    input  logic [W_RD-1:0]  r1_i,
    output logic [W_OPR-1:0] r_opr0_o,
    output logic [W_OPR-1:0] r_opr1_o,
    input  logic             w_reserve_i,
    input  logic [W_RD-1:0]  w_reserve_r_i,
    output logic             reserved_o,
    input  logic             wb_i,
    input  logic [W_RD-1:0]  wb_r_i,
    input  logic [W_OPR-1:0] result_i,
    input  logic             flush_i,
    output logic [N_REG-1:0] busy_o,
    output logic             err_o
);

    // Reservation handshake: w_reserve_i acts as valid and !reserved_o acts as
    // ready. A reservation is taken only at a posedge where both are true and
    // no flush is present. Decode must hold the request while reserved_o is high.

    localparam logic [W_CNT-1:0] CNT_MAX = '1;
    localparam logic [W_CNT-1:0] CNT_ONE = 1;

    logic [W_OPR-1:0] regs_q [N_REG];
    logic [W_CNT-1:0] cnt_q  [N_REG];
    logic [W_CNT-1:0] cnt_d  [N_REG];
    logic             err_q, err_d;

    logic byp0, byp1;
    logic haz0, haz1, haz_w;
    logic res_accept, wb_take;

    // r0 is hardwired to zero only when ZERO_R0 is set.
    function automatic logic exempt(input logic [W_RD-1:0] idx);
        return (ZERO_R0 != 0) && (idx == '0);
    endfunction

    // Forwarding. When the write in flight is the only outstanding one, the
    // operand can take result_i directly.
    always_comb begin
        byp0 = 1'b0;
        byp1 = 1'b0;
`ifdef VENUS_REG_BYPASS_EN
        byp0 = wb_i && !exempt(wb_r_i) && (wb_r_i == r0_i) && (cnt_q[r0_i] == CNT_ONE);
        byp1 = wb_i && !exempt(wb_r_i) && (wb_r_i == r1_i) && (cnt_q[r1_i] == CNT_ONE);
`endif
    end

    // Hazard detection and operand read mux.
    always_comb begin
        haz0       = !exempt(r0_i) && (cnt_q[r0_i] != '0) && !byp0;
        haz1       = !exempt(r1_i) && (cnt_q[r1_i] != '0) && !byp1;
        haz_w      = w_reserve_i && !exempt(w_reserve_r_i) && (cnt_q[w_reserve_r_i] == CNT_MAX);
        reserved_o = haz0 || haz1 || haz_w;
        res_accept = w_reserve_i && !reserved_o && !flush_i && !exempt(w_reserve_r_i);
        wb_take    = wb_i && !exempt(wb_r_i);

        r_opr0_o = regs_q[r0_i];
        if (exempt(r0_i)) r_opr0_o = '0;
        else if (byp0)    r_opr0_o = result_i;

        r_opr1_o = regs_q[r1_i];
        if (exempt(r1_i)) r_opr1_o = '0;
        else if (byp1)    r_opr1_o = result_i;
    end

    // Next counter values. Flush wins over all other updates. A same-cycle
    // reserve and write-back to the same register cancel each other out.
    always_comb begin
        err_d = err_q;
        if (wb_take && (cnt_q[wb_r_i] == '0)) err_d = 1'b1;
        for (int k = 0; k < N_REG; k++) begin
            cnt_d[k] = cnt_q[k];
            if (flush_i) begin
                cnt_d[k] = '0;
            end else if ((res_accept && (w_reserve_r_i == W_RD'(k))) &&
                         !(wb_take && (wb_r_i == W_RD'(k)) && (cnt_q[k] != '0))) begin
                cnt_d[k] = cnt_q[k] + CNT_ONE;
            end else if (!(res_accept && (w_reserve_r_i == W_RD'(k))) &&
                         (wb_take && (wb_r_i == W_RD'(k)) && (cnt_q[k] != '0))) begin
                cnt_d[k] = cnt_q[k] - CNT_ONE;
            end
        end
    end

    // Busy vector: one bit per register with outstanding writes.
    always_comb begin
        busy_o = '0;
        for (int k = 0; k < N_REG; k++) busy_o[k] = (cnt_q[k] != '0);
    end

    assign err_o = err_q;

    // State registers: data, counters and the sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N_REG; k++) begin
                regs_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int k = 0; k < N_REG; k++) cnt_q[k] <= cnt_d[k];
            err_q <= err_d;
            if (wb_take) regs_q[wb_r_i] <= result_i;
        end
    end

endmodule
